// File: rtl/monitor_pkg.sv
// Shared definitions for the multicore test monitor: FSM state codes,
// register-index width and a saturating counter increment.
package monitor_pkg;

  localparam int REG_IDX_W = 5;
  localparam int SAT_W     = 32;

  typedef logic [1:0] state_t;

  localparam state_t S_RESET = 2'd0;
  localparam state_t S_RUN   = 2'd1;
  localparam state_t S_PASS  = 2'd2;
  localparam state_t S_FAIL  = 2'd3;

  // Increments v, holding at the all-ones value of a w-bit counter.
  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] v, input int w);
    logic [SAT_W-1:0] lim;
    lim = {SAT_W{1'b1}} >> (SAT_W - w);
    return (v >= lim) ? v : v + SAT_W'(1);
  endfunction

endpackage

// File: rtl/multicore_test_monitor_snoop.sv
// Per-hart writeback snooper: tracks match/mismatch of the checked register and,
// when MONITOR_PERF_EN is defined, per-hart retire and stall counters.
module monitor_hart_snoop
  import monitor_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter int              CHECK_REG  = 4,
  parameter logic [XLEN-1:0] EXPECT_VAL = 12,
  parameter int              CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 run,
  input  logic                 wb_valid,
  input  logic [REG_IDX_W-1:0] wb_rd,
  input  logic [XLEN-1:0]      wb_data,
  input  logic                 hart_stall,
  output logic                 matched,
  output logic                 mismatch,
  output logic                 matched_next,
  output logic [CNT_W-1:0]     retire_cnt,
  output logic [CNT_W-1:0]     stall_cnt
);

  logic matched_q, matched_d;
  logic mismatch_q, mismatch_d;
  logic hit;

  always_comb begin
    hit        = run && wb_valid && (wb_rd == REG_IDX_W'(CHECK_REG));
    matched_d  = matched_q;
    mismatch_d = mismatch_q;
    if (clr) begin
      matched_d  = 1'b0;
      mismatch_d = 1'b0;
    end else if (hit) begin
      matched_d  = (wb_data == EXPECT_VAL);
      mismatch_d = (wb_data != EXPECT_VAL);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      matched_q  <= 1'b0;
      mismatch_q <= 1'b0;
    end else begin
      matched_q  <= matched_d;
      mismatch_q <= mismatch_d;
    end
  end

  assign matched      = matched_q;
  assign mismatch     = mismatch_q;
  assign matched_next = matched_d;

`ifdef MONITOR_PERF_EN
  logic [CNT_W-1:0] retire_q, retire_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  // Retire counts any valid writeback during the run, x0 included.
  always_comb begin
    retire_d = retire_q;
    stall_d  = stall_q;
    if (clr) begin
      retire_d = '0;
      stall_d  = '0;
    end else if (run) begin
      if (wb_valid)   retire_d = CNT_W'(sat_inc(SAT_W'(retire_q), CNT_W));
      if (hart_stall) stall_d  = CNT_W'(sat_inc(SAT_W'(stall_q), CNT_W));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      retire_q <= '0;
      stall_q  <= '0;
    end else begin
      retire_q <= retire_d;
      stall_q  <= stall_d;
    end
  end

  assign retire_cnt = retire_q;
  assign stall_cnt  = stall_q;
`else
  logic unused_stall;
  assign unused_stall = hart_stall;
  assign retire_cnt   = '0;
  assign stall_cnt    = '0;
`endif

endmodule

// File: rtl/multicore_test_monitor.sv
// Bring-up monitor: sequences core reset, snoops every hart's writeback and
// reports PASS/FAIL. Optional perf counters are built with MONITOR_PERF_EN.
module multicore_test_monitor
  import monitor_pkg::*;
#(
  parameter int              NUM_HARTS      = 2,
  parameter int              XLEN           = 32,
  parameter int              RESET_CYCLES   = 2,
  parameter int              TIMEOUT_CYCLES = 20,
  parameter int              CHECK_REG      = 4,
  parameter logic [XLEN-1:0] EXPECT_VAL     = 12,
  parameter int              CNT_W          = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [NUM_HARTS-1:0]          wb_valid,
  input  logic [REG_IDX_W*NUM_HARTS-1:0] wb_rd,
  input  logic [XLEN*NUM_HARTS-1:0]     wb_data,
  input  logic [NUM_HARTS-1:0]          hart_stall,
  output logic                          core_rst_n,
  output logic                          done,
  output logic                          pass,
  output logic                          fail,
  output logic [NUM_HARTS-1:0]          matched_mask,
  output logic [NUM_HARTS-1:0]          mismatch_mask,
  output logic [CNT_W-1:0]              cycle_cnt,
  output logic [CNT_W*NUM_HARTS-1:0]    retire_cnt,
  output logic [CNT_W*NUM_HARTS-1:0]    stall_cnt,
  output state_t                        dbg_state
);

  if (CHECK_REG < 1 || CHECK_REG > 31) begin : g_bad_check_reg
    $error("CHECK_REG must be in 1..31");
  end
  if (RESET_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cycles
    $error("RESET_CYCLES and TIMEOUT_CYCLES must be >= 1");
  end
  if (CNT_W < 1 || CNT_W > SAT_W) begin : g_bad_cnt_w
    $error("CNT_W must be in 1..32");
  end

  localparam int RST_W = $clog2(RESET_CYCLES + 1);

  state_t           state_q, state_d;
  logic [RST_W-1:0] rst_cnt_q, rst_cnt_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic             core_rst_n_q, core_rst_n_d;
  logic             done_q, done_d, pass_q, pass_d, fail_q, fail_d;
  logic             run, clr;
  logic [NUM_HARTS-1:0] matched_next;

  assign run = (state_q == S_RUN);
  assign clr = start && ((state_q == S_PASS) || (state_q == S_FAIL));

  for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
    monitor_hart_snoop #(
      .XLEN      (XLEN),
      .CHECK_REG (CHECK_REG),
      .EXPECT_VAL(EXPECT_VAL),
      .CNT_W     (CNT_W)
    ) u_snoop (
      .clk         (clk),
      .rst         (rst),
      .clr         (clr),
      .run         (run),
      .wb_valid    (wb_valid[h]),
      .wb_rd       (wb_rd[REG_IDX_W*h +: REG_IDX_W]),
      .wb_data     (wb_data[XLEN*h +: XLEN]),
      .hart_stall  (hart_stall[h]),
      .matched     (matched_mask[h]),
      .mismatch    (mismatch_mask[h]),
      .matched_next(matched_next[h]),
      .retire_cnt  (retire_cnt[CNT_W*h +: CNT_W]),
      .stall_cnt   (stall_cnt[CNT_W*h +: CNT_W])
    );
  end

  // PASS is judged on masks that include this cycle's writes, so it beats
  // a timeout landing in the same cycle.
  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    cycle_d   = cycle_q;
    case (state_q)
      S_RESET: begin
        rst_cnt_d = rst_cnt_q + RST_W'(1);
        if (rst_cnt_q == RST_W'(RESET_CYCLES - 1)) begin
          state_d   = S_RUN;
          rst_cnt_d = '0;
        end
      end
      S_RUN: begin
        cycle_d = CNT_W'(sat_inc(SAT_W'(cycle_q), CNT_W));
        if (&matched_next)                               state_d = S_PASS;
        else if (cycle_q == CNT_W'(TIMEOUT_CYCLES - 1)) state_d = S_FAIL;
      end
      S_PASS, S_FAIL: begin
        if (start) begin
          state_d   = S_RESET;
          rst_cnt_d = '0;
          cycle_d   = '0;
        end
      end
      default: state_d = S_RESET;
    endcase
    core_rst_n_d = (state_d != S_RESET);
    pass_d       = (state_d == S_PASS);
    fail_d       = (state_d == S_FAIL);
    done_d       = pass_d || fail_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_RESET;
      rst_cnt_q    <= '0;
      cycle_q      <= '0;
      core_rst_n_q <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rst_cnt_q    <= rst_cnt_d;
      cycle_q      <= cycle_d;
      core_rst_n_q <= core_rst_n_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      fail_q       <= fail_d;
    end
  end

  assign core_rst_n = core_rst_n_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign fail       = fail_q;
  assign cycle_cnt  = cycle_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_multicore_test_monitor.sv
// Scoreboard bench for multicore_test_monitor: drivers push expected reset-release,
// mask-change and end-of-run records; a negedge monitor pops and compares them.
module tb_multicore_test_monitor;
  import monitor_pkg::*;

  localparam int NH = 2;
  localparam int XL = 32;
  localparam int CW = 16;

  logic              clk;
  logic              rst;
  logic              start;
  logic [NH-1:0]     wb_valid;
  logic [5*NH-1:0]   wb_rd;
  logic [XL*NH-1:0]  wb_data;
  logic [NH-1:0]     hart_stall;
  logic              core_rst_n, done, pass, fail;
  logic [NH-1:0]     matched_mask, mismatch_mask;
  logic [CW-1:0]     cycle_cnt;
  logic [CW*NH-1:0]  retire_cnt, stall_cnt;
  state_t            dbg_state;

  multicore_test_monitor dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .hart_stall   (hart_stall),
    .core_rst_n   (core_rst_n),
    .done         (done),
    .pass         (pass),
    .fail         (fail),
    .matched_mask (matched_mask),
    .mismatch_mask(mismatch_mask),
    .cycle_cnt    (cycle_cnt),
    .retire_cnt   (retire_cnt),
    .stall_cnt    (stall_cnt),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got hang want finish");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic        p;
    logic        f;
    logic [1:0]  m;
    logic [1:0]  mm;
    logic [15:0] cyc;
    logic [15:0] r0;
    logic [15:0] s0;
    logic [15:0] r1;
    logic [15:0] s1;
  } end_t;

  logic [7:0] start_q[$];
  logic [3:0] mask_q[$];
  end_t       end_q[$];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    total++;
    bad++;
    $display("FAIL %s: got unexpected event want none", name);
  endtask

  function automatic logic [15:0] pf(input int v);
`ifdef MONITOR_PERF_EN
    return 16'(v);
`else
    return (v == 0) ? 16'd0 : 16'd0;
`endif
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [1:0] v, input logic [4:0] rd0, input logic [31:0] d0,
                        input logic [4:0] rd1, input logic [31:0] d1, input logic [1:0] st);
    wb_valid   = v;
    wb_rd      = {rd1, rd0};
    wb_data    = {d1, d0};
    hart_stall = st;
  endtask

  task automatic cyc(input logic [1:0] v, input logic [4:0] rd0, input logic [31:0] d0,
                     input logic [4:0] rd1, input logic [31:0] d1, input logic [1:0] st);
    set_in(v, rd0, d0, rd1, d1, st);
    step();
    set_in(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 2'b00);
  endtask

  task automatic wait_run();
    int n = 0;
    while (core_rst_n !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check("wait_run_bound", {63'd0, core_rst_n}, 64'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    wait_run();
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_run();
  endtask

  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < 60) begin
      step();
      n++;
    end
    check("wait_done_bound", {63'd0, done}, 64'd1);
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    logic        prev_n, prev_done;
    logic [3:0]  prev_m, cur_m;
    logic [79:0] prev_frz, cur_frz;
    int          low_cnt;
    logic [7:0]  exp_low;
    logic [3:0]  exp_m;
    end_t        e;
    prev_n    = 1'b0;
    prev_done = 1'b0;
    prev_m    = '0;
    prev_frz  = '0;
    low_cnt   = 0;
    forever begin
      @(negedge clk);
      cur_m   = {matched_mask, mismatch_mask};
      cur_frz = {cycle_cnt, retire_cnt, stall_cnt};
      if (rst) low_cnt = 0;
      else if (core_rst_n === 1'b0) low_cnt++;
      // core released: reset sequence finished, everything must be clean
      if (!rst && core_rst_n === 1'b1 && prev_n === 1'b0) begin
        if (start_q.size() == 0) unexpected("release");
        else begin
          exp_low = start_q.pop_front();
          check("rst_low_len", 64'(low_cnt), 64'(exp_low));
          check("run_state", 64'(dbg_state), 64'(S_RUN));
          check("release_masks", 64'(cur_m), 64'd0);
          check("release_cycle", 64'(cycle_cnt), 64'd0);
          check("release_flags", {61'd0, done, pass, fail}, 64'd0);
          check("release_perf", {retire_cnt, stall_cnt}, 64'd0);
        end
      end
      if (core_rst_n === 1'b1) low_cnt = 0;
      if (!rst && cur_m !== prev_m && dbg_state != S_RESET) begin
        if (mask_q.size() == 0) unexpected("mask_change");
        else begin
          exp_m = mask_q.pop_front();
          check("masks", 64'(cur_m), 64'(exp_m));
        end
      end
      if (done === 1'b1 && prev_done !== 1'b1) begin
        if (end_q.size() == 0) unexpected("done");
        else begin
          e = end_q.pop_front();
          check("end_pass", 64'(pass), 64'(e.p));
          check("end_fail", 64'(fail), 64'(e.f));
          check("end_state", 64'(dbg_state), e.p ? 64'(S_PASS) : 64'(S_FAIL));
          check("end_matched", 64'(matched_mask), 64'(e.m));
          check("end_mismatch", 64'(mismatch_mask), 64'(e.mm));
          check("end_cycle", 64'(cycle_cnt), 64'(e.cyc));
          check("end_retire", 64'(retire_cnt), {32'd0, e.r1, e.r0});
          check("end_stall", 64'(stall_cnt), {32'd0, e.s1, e.s0});
          check("end_core_rst_n", 64'(core_rst_n), 64'd1);
        end
      end else if (done === 1'b1 && prev_done === 1'b1) begin
        check("frozen_counters", cur_frz[63:0], prev_frz[63:0]);
        check("frozen_cycle", 64'(cur_frz[79:64]), 64'(prev_frz[79:64]));
      end
      prev_n    = core_rst_n;
      prev_done = done;
      prev_m    = cur_m;
      prev_frz  = cur_frz;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst   = 1'b1;
    start = 1'b0;
    set_in(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 2'b00);

    // Reset sequence, then PASS with ignored x0/x5 writes and stall traffic
    start_q.push_back(8'd2);
    do_reset();
    mask_q.push_back(4'b0100);
    mask_q.push_back(4'b1100);
    end_q.push_back('{p:1'b1, f:1'b0, m:2'b11, mm:2'b00, cyc:16'd6,
                      r0:pf(5), s0:pf(3), r1:pf(3), s1:pf(1)});
    cyc(2'b11, 5'd5, 32'd12, 5'd0, 32'd12, 2'b01);
    cyc(2'b11, 5'd5, 32'd12, 5'd5, 32'd12, 2'b01);
    cyc(2'b01, 5'd0, 32'd12, 5'd0, 32'd0,  2'b01);
    cyc(2'b01, 5'd4, 32'd12, 5'd0, 32'd0,  2'b00);
    cyc(2'b01, 5'd0, 32'd0,  5'd0, 32'd0,  2'b10);
    cyc(2'b10, 5'd0, 32'd0,  5'd4, 32'd12, 2'b00);
    wait_done();
    // writes and stalls in a terminal state must not be snooped
    cyc(2'b11, 5'd4, 32'd7, 5'd4, 32'd7, 2'b11);
    cyc(2'b11, 5'd4, 32'd7, 5'd4, 32'd7, 2'b11);
    repeat (2) step();

    // Re-arm; wrong value then correction on hart0, hart1 silent -> timeout
    start_q.push_back(8'd2);
    do_start();
    mask_q.push_back(4'b0001);
    mask_q.push_back(4'b0100);
    end_q.push_back('{p:1'b0, f:1'b1, m:2'b01, mm:2'b00, cyc:16'd20,
                      r0:pf(2), s0:pf(0), r1:pf(0), s1:pf(0)});
    cyc(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 2'b00);
    cyc(2'b01, 5'd4, 32'd7,  5'd0, 32'd0, 2'b00);
    cyc(2'b01, 5'd4, 32'd12, 5'd0, 32'd0, 2'b00);
    wait_done();
    repeat (2) step();

    // Only hart1 matches -> timeout with matched_mask=10
    start_q.push_back(8'd2);
    do_start();
    mask_q.push_back(4'b1000);
    end_q.push_back('{p:1'b0, f:1'b1, m:2'b10, mm:2'b00, cyc:16'd20,
                      r0:pf(0), s0:pf(0), r1:pf(1), s1:pf(0)});
    cyc(2'b10, 5'd0, 32'd0, 5'd4, 32'd12, 2'b00);
    wait_done();
    repeat (2) step();

    // Ignored x0/x5 writes, then both match in cycle 19: PASS beats timeout
    start_q.push_back(8'd2);
    do_start();
    mask_q.push_back(4'b1100);
    end_q.push_back('{p:1'b1, f:1'b0, m:2'b11, mm:2'b00, cyc:16'd20,
                      r0:pf(3), s0:pf(0), r1:pf(3), s1:pf(0)});
    cyc(2'b11, 5'd0, 32'd12, 5'd0, 32'd12, 2'b00);
    cyc(2'b11, 5'd5, 32'd12, 5'd5, 32'd12, 2'b00);
    repeat (17) step();
    cyc(2'b11, 5'd4, 32'd12, 5'd4, 32'd12, 2'b00);
    wait_done();
    repeat (2) step();

    // start ignored in S_RUN, then rst mid-run restarts cleanly
    start_q.push_back(8'd2);
    do_start();
    mask_q.push_back(4'b0100);
    cyc(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 2'b00);
    cyc(2'b01, 5'd4, 32'd12, 5'd0, 32'd0, 2'b00);
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    start_q.push_back(8'd2);
    do_reset();
    mask_q.push_back(4'b1100);
    end_q.push_back('{p:1'b1, f:1'b0, m:2'b11, mm:2'b00, cyc:16'd1,
                      r0:pf(1), s0:pf(0), r1:pf(1), s1:pf(0)});
    cyc(2'b11, 5'd4, 32'd12, 5'd4, 32'd12, 2'b00);
    wait_done();
    repeat (3) step();

    check("start_q_drained", 64'(start_q.size()), 64'd0);
    check("mask_q_drained", 64'(mask_q.size()), 64'd0);
    check("end_q_drained", 64'(end_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicore_test_monitor.md
Name: multicore_test_monitor

Overview:
Synthesizable self-checking harness block for multi-hart core bring-up. It sequences core reset, then snoops each hart's writeback port. It declares PASS when every hart has written an expected value to a designated architectural register, and FAIL on timeout. It sits beside the core array in simulation and FPGA test tops, replacing ad-hoc testbench delays and end-of-run register peeks.

Parameters:
- NUM_HARTS, 2, number of snooped writeback ports
- XLEN, 32, data width
- RESET_CYCLES, 2, cycles core_rst_n is held low after entering S_RESET (>=1)
- TIMEOUT_CYCLES, 20, max run cycles before FAIL (>=1)
- CHECK_REG, 4, register index checked (1..31; 0 illegal, elaboration error)
- EXPECT_VAL, 12, value required in CHECK_REG
- CNT_W, 16, width of cycle/perf counters

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- start  in  1  pulse; in S_PASS/S_FAIL re-arms a run
- wb_valid  in  NUM_HARTS  per-hart writeback enable (mem_wb_reg_write)
- wb_rd  in  5*NUM_HARTS  per-hart destination index, hart h at [5h+4:5h]
- wb_data  in  XLEN*NUM_HARTS  per-hart write data
- hart_stall  in  NUM_HARTS  per-hart pipeline stall (perf only)
- core_rst_n  out  1  reset to core array, active-low
- done  out  1  high in S_PASS or S_FAIL
- pass  out  1  high in S_PASS
- fail  out  1  high in S_FAIL
- matched_mask  out  NUM_HARTS  hart h's latest CHECK_REG write equals EXPECT_VAL
- mismatch_mask  out  NUM_HARTS  hart h's latest CHECK_REG write differs from EXPECT_VAL
- cycle_cnt  out  CNT_W  run cycles elapsed in S_RUN
- retire_cnt  out  CNT_W*NUM_HARTS  per-hart wb_valid count (perf)
- stall_cnt  out  CNT_W*NUM_HARTS  per-hart stall count (perf)

Behaviour:
- One clock; reset is synchronous and active-high.
- rst: state=S_RESET, reset counter=0, cycle_cnt=0, masks=0, perf counters=0, core_rst_n=0, done/pass/fail=0. rst mid-run aborts and restarts the sequence identically.
- S_RESET: core_rst_n=0 (registered). Reset counter increments each cycle. At count RESET_CYCLES-1, go to S_RUN; core_rst_n=1 from the first S_RUN cycle. Exactly RESET_CYCLES low cycles after rst deasserts.
- S_RUN: cycle_cnt increments every cycle and saturates at all-ones. For each hart h in the same cycle:
  - A write counts only when wb_valid[h]=1 and wb_rd[h]==CHECK_REG.
  - On such a write: matched[h] = (wb_data[h]==EXPECT_VAL); mismatch[h] = the inverse.
  - Writes to x0 or other registers are ignored.
  - Simultaneous writes from several harts are all applied.
- Next-state from S_RUN, evaluated on mask values including this cycle's writes:
  - All matched: go to S_PASS.
  - Else if cycle_cnt==TIMEOUT_CYCLES-1: go to S_FAIL.
  - PASS has priority when both conditions hit on the same cycle.
- Mismatch alone does not fail; a later correct write clears it. Timeout is the only fail path.
- S_PASS/S_FAIL: terminal.
  - Masks and cycle_cnt frozen; core_rst_n stays 1; snooping stops.
  - start=1: go to S_RESET and clear masks, cycle_cnt and perf counters.
  - start is ignored in S_RESET and S_RUN.
- Outputs are registered from state: done/pass/fail assert the cycle after the deciding write/timeout.

Optional Feature:
- MONITOR_PERF_EN defined: retire_cnt[h] increments on wb_valid[h] in S_RUN (any rd, including x0). stall_cnt[h] increments on hart_stall[h] in S_RUN. Both saturate and are cleared on rst/start.
- Undefined: counter logic is not built; retire_cnt and stall_cnt are tied to 0; hart_stall is unused. Ports remain so tops are unchanged.

Decomposition:
- Shared package monitor_pkg:
  - state enum S_RESET/S_RUN/S_PASS/S_FAIL
  - REG_IDX_W=5
  - saturating-increment function
- One natural sub-module: monitor_hart_snoop, instantiated per hart (generate loop). It holds matched/mismatch flags and perf counters.
- The top keeps the FSM, reset sequencer and cycle counter.

Test Plan:
- Reset sequence: rst high 3 cycles then low, RESET_CYCLES=2 -> core_rst_n low exactly 2 cycles post-rst, then 1; state S_RUN.
- Pass, 2 harts: hart0 writes x4=12 at run cycle 3, hart1 x4=12 at cycle 5 -> matched_mask=2'b01 then 2'b11; pass=1, done=1 next cycle; cycle_cnt frozen at 6.
- Correction: hart0 writes x4=7 (mismatch_mask=01), then x4=12 -> mismatch_mask=00, matched_mask=01; no fail.
- Timeout: only hart1 writes x4=12; TIMEOUT_CYCLES=20 -> fail=1 after run cycle 19; matched_mask=10; cycle_cnt=20.
- Ignored writes and tie-break: both harts write x0=12 and x5=12 -> masks stay 0. Both harts write x4=12 in cycle 19 -> pass, not fail.
- Re-arm and mid-run reset: start in S_FAIL -> S_RESET with masks/counters 0 and core_rst_n low 2 cycles. rst asserted in S_RUN -> same clean restart. With MONITOR_PERF_EN, 5 wb_valid and 3 stall cycles on hart0 -> retire_cnt[0]=5, stall_cnt[0]=3.
